udp_tx_packetizer: RTL and testbench
====================================

Name: udp_tx_packetizer

Overview:
- Upstream feeder for the UDP/GMII transmit stage.
- Accepts a byte stream from user logic and packs it big-endian into 32-bit words in an internal buffer.
- Closes a packet on last-byte, size limit or idle timeout, then starts the transmitter with the byte count.
- Serves 32-bit words on the transmitter's per-word requests and waits for its completion before accepting new bytes.

Parameters:
MAX_BYTES, 1472, maximum payload bytes per packet; a packet closes when this count is reached.
ADDR_W, 9, word-buffer address width; 2^ADDR_W words must be >= ceil(MAX_BYTES/4).
TIMEOUT_CYC, 125000, idle cycles with a partial packet before a forced close (only with the optional feature).

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous reset, active-low
in_valid  input  1  byte valid
in_data  input  8  payload byte
in_last  input  1  final byte of the packet; qualified by in_valid
in_ready  output  1  byte accepted when in_valid && in_ready
tx_start_en  output  1  start request to the transmitter (level, 2-cycle pulse)
tx_byte_num  output  16  payload byte count of the closed packet
tx_req  input  1  one-cycle request for the next payload word
tx_data  output  32  payload word; first byte in [31:24]
tx_done  input  1  one-cycle pulse: frame fully transmitted
busy  output  1  high from packet close until tx_done

Behaviour:
- Reset values: in_ready=0, tx_start_en=0, tx_byte_num=0, tx_data=0, busy=0. Counters, addresses and the state machine are cleared.
- Reset mid-operation aborts everything. Buffered bytes are discarded and no start is issued.
- States: IDLE, FILL, FLUSH, START, SEND.
- IDLE:
  - in_ready=1.
  - The first accepted byte moves to FILL.
  - If that byte has in_last set, go directly to FLUSH.
- FILL:
  - in_ready=1; each accepted byte increments byte_cnt (16 bit).
  - Packing: byte_cnt[1:0]=0,1,2,3 places the byte into [31:24],[23:16],[15:8],[7:0] of the pack register.
  - A full word is written to buffer[wr_addr] on the cycle its 4th byte is accepted; wr_addr then increments.
  - Close condition: in_last accepted, or byte_cnt reaches MAX_BYTES. On close go to FLUSH; in_ready is 0 from the next cycle.
- FLUSH (1 cycle):
  - If byte_cnt[1:0]!=0, write the partial word with unused low bytes set to 0.
  - Latch tx_byte_num=byte_cnt, set busy=1, go to START.
- START (2 cycles): tx_start_en=1, then 0 on leaving. rd_addr=0. Go to SEND.
- SEND:
  - On each tx_req, tx_data <= buffer[rd_addr] at the next clock edge, i.e. valid 1 cycle after tx_req and held until the next tx_req. rd_addr then increments.
  - Requests beyond ceil(tx_byte_num/4) words return tx_data=0. This supplies the transmitter's minimum-frame padding.
  - tx_req before the first request is ignored.
  - tx_done: busy=0, byte_cnt/wr_addr/rd_addr cleared, go to IDLE. tx_done in any other state is ignored.
- in_ready is 0 in FLUSH, START and SEND. No bytes are lost; the source is stalled.
- A zero-length packet is never started. in_last without in_valid is ignored.
- Simultaneous tx_req and tx_done in SEND: tx_done wins and the read is discarded.
- Buffer is a simple dual-port RAM with synchronous read, inferable as block RAM.

Optional Feature:
- Macro PKTZ_TIMEOUT_FLUSH_EN.
- When defined:
  - An idle counter runs in FILL. It clears on each accepted byte and increments otherwise.
  - When it reaches TIMEOUT_CYC-1 with byte_cnt>0, the packet closes via FLUSH exactly as for in_last.
  - The counter is cleared outside FILL.
- When undefined: no counter is present; a packet closes only on in_last or MAX_BYTES, and a partial packet waits indefinitely.

Test Plan:
- Send bytes 0x01..0x08 with in_last on 0x08 -> tx_start_en high 2 cycles, tx_byte_num=8. Successive tx_req give 0x01020304, then 0x05060708, then 0x00000000. tx_done returns to IDLE with in_ready=1.
- 5 bytes 0xA1..0xA5 with in_last -> tx_byte_num=5; words 0xA1A2A3A4, then 0xA5000000.
- 1500 bytes continuous, no in_last -> close at 1472, tx_byte_num=1472, in_ready=0 from the next cycle. The 1473rd byte stalls until tx_done, then forms the first byte of the next packet.
- tx_req exactly 1 cycle after start; 1-cycle spacing between requests and 4-cycle spacing between requests -> tx_data updates exactly 1 cycle after each tx_req and is stable otherwise.
- Assert rst_n low in the middle of SEND -> all outputs at reset values. The next 4-byte packet after reset sends from word 0 with tx_byte_num=4.
- With PKTZ_TIMEOUT_FLUSH_EN and TIMEOUT_CYC=100: 3 bytes 0x11,0x22,0x33 then idle -> close after 100 idle cycles, tx_byte_num=3, word 0x11223300. Without the macro: no start after 10000 idle cycles.

Source files
------------

// File: rtl/udp_tx_packetizer.sv
// Packs a byte stream big-endian into 32-bit words, closes a packet on last/size limit, then hands it to the transmitter word by word.
// Optional idle-timeout close is compiled in when PKTZ_TIMEOUT_FLUSH_EN is defined.
module udp_tx_packetizer #(
    parameter int MAX_BYTES   = 1472,
    parameter int ADDR_W      = 9,
    parameter int TIMEOUT_CYC = 125000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    output logic        in_ready,
    output logic        tx_start_en,
    output logic [15:0] tx_byte_num,
    input  logic        tx_req,
    output logic [31:0] tx_data,
    input  logic        tx_done,
    output logic        busy,
    output logic [2:0]  dbg_state
);

    // Byte handshake: a byte transfers on a rising clk edge where in_valid && in_ready;
    // in_ready only depends on internal state, never combinationally on in_valid.
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        FLUSH = 3'd2,
        START = 3'd3,
        SEND  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [15:0]         byte_cnt_q, byte_cnt_d;
    logic [31:0]         pack_q, pack_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic [15:0]         rd_cnt_q, rd_cnt_d;
    logic [15:0]         byte_num_q, byte_num_d;
    logic                busy_q, busy_d;
    logic                in_ready_q, in_ready_d;
    logic                start_cyc_q, start_cyc_d;
    logic                data_ok_q, data_ok_d;

    logic                accept;
    logic [15:0]         cnt_inc;
    logic [31:0]         pack_next;
    logic [15:0]         num_words;
    logic                wr_en;
    logic [31:0]         wr_data;
    logic                rd_en;
    logic                idle_hit;

    logic [31:0]         mem [0:(2**ADDR_W)-1];
    logic [31:0]         ram_rd_q;

    assign accept    = in_valid && in_ready_q;
    assign cnt_inc   = byte_cnt_q + 16'd1;
    assign num_words = (byte_num_q + 16'd3) >> 2;

    always_comb begin
        pack_next = pack_q;
        case (byte_cnt_q[1:0])
            2'd0:    pack_next = {in_data, 24'h000000};
            2'd1:    pack_next[23:16] = in_data;
            2'd2:    pack_next[15:8]  = in_data;
            default: pack_next[7:0]   = in_data;
        endcase
    end

`ifdef PKTZ_TIMEOUT_FLUSH_EN
    logic [31:0] idle_cnt_q, idle_cnt_d;

    assign idle_hit = (idle_cnt_q == 32'(TIMEOUT_CYC - 1)) && (byte_cnt_q != 16'd0);

    always_comb begin
        idle_cnt_d = '0;
        if (state_q == FILL && !accept && !idle_hit) begin
            idle_cnt_d = idle_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idle_cnt_q <= '0;
        end else begin
            idle_cnt_q <= idle_cnt_d;
        end
    end
`else
    // TIMEOUT_CYC only matters in the timeout build; a partial packet waits here.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC != 0);
    assign idle_hit       = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        pack_d      = pack_q;
        wr_addr_d   = wr_addr_q;
        rd_cnt_d    = rd_cnt_q;
        byte_num_d  = byte_num_q;
        busy_d      = busy_q;
        start_cyc_d = start_cyc_q;
        data_ok_d   = data_ok_q;
        wr_en       = 1'b0;
        wr_data     = pack_next;
        rd_en       = 1'b0;

        case (state_q)
            IDLE, FILL: begin
                if (accept) begin
                    pack_d     = pack_next;
                    byte_cnt_d = cnt_inc;
                    if (byte_cnt_q[1:0] == 2'd3) begin
                        wr_en     = 1'b1;
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                    if (in_last || cnt_inc == 16'(MAX_BYTES)) begin
                        state_d = FLUSH;
                    end else begin
                        state_d = FILL;
                    end
                end else if (state_q == FILL && idle_hit) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                // pack_q already has zeros in the lanes not yet filled
                if (byte_cnt_q[1:0] != 2'd0) begin
                    wr_en   = 1'b1;
                    wr_data = pack_q;
                end
                byte_num_d  = byte_cnt_q;
                busy_d      = 1'b1;
                start_cyc_d = 1'b0;
                state_d     = START;
            end
            START: begin
                rd_cnt_d    = '0;
                start_cyc_d = 1'b1;
                if (start_cyc_q) begin
                    state_d = SEND;
                end
            end
            SEND: begin
                if (tx_done) begin
                    busy_d     = 1'b0;
                    byte_cnt_d = '0;
                    wr_addr_d  = '0;
                    rd_cnt_d   = '0;
                    state_d    = IDLE;
                end else if (tx_req) begin
                    // reads past the packet return zero as frame padding
                    rd_en     = 1'b1;
                    data_ok_d = (rd_cnt_q < num_words);
                    rd_cnt_d  = rd_cnt_q + 16'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        in_ready_d = (state_d == IDLE) || (state_d == FILL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            byte_cnt_q  <= '0;
            pack_q      <= '0;
            wr_addr_q   <= '0;
            rd_cnt_q    <= '0;
            byte_num_q  <= '0;
            busy_q      <= 1'b0;
            in_ready_q  <= 1'b0;
            start_cyc_q <= 1'b0;
            data_ok_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            pack_q      <= pack_d;
            wr_addr_q   <= wr_addr_d;
            rd_cnt_q    <= rd_cnt_d;
            byte_num_q  <= byte_num_d;
            busy_q      <= busy_d;
            in_ready_q  <= in_ready_d;
            start_cyc_q <= start_cyc_d;
            data_ok_q   <= data_ok_d;
        end
    end

    // Simple dual-port word buffer, synchronous read, no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr_q] <= wr_data;
        end
        if (rd_en) begin
            ram_rd_q <= mem[rd_cnt_q[ADDR_W-1:0]];
        end
    end

    assign in_ready    = in_ready_q;
    assign tx_start_en = (state_q == START);
    assign tx_byte_num = byte_num_q;
    assign tx_data     = data_ok_q ? ram_rd_q : 32'h0;
    assign busy        = busy_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_udp_tx_packetizer.sv
// Scoreboard bench for udp_tx_packetizer: a byte-level packet model predicts words and byte counts,
// a transmitter emulator issues requests, and a monitor compares tx_data against the expected queue.
`timescale 1ns/1ps
module tb_udp_tx_packetizer;

    localparam int MAX_BYTES   = 1472;
    localparam int TO_CYC      = 100;
    localparam int STALL_LIMIT = 6000;
    localparam int START_LIMIT = 6000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_last = 1'b0;
    logic        tx_req = 1'b0;
    logic        tx_done = 1'b0;
    logic        in_ready;
    logic        tx_start_en;
    logic [15:0] tx_byte_num;
    logic [31:0] tx_data;
    logic        busy;
    logic [2:0]  dbg_state;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] exp_q[$];
    int          num_q[$];
    logic [7:0]  cur_q[$];
    logic [7:0]  src_data[$];
    logic        src_last[$];

    logic        req_seen = 1'b0;
    logic [31:0] hold_val = 32'h0;

    udp_tx_packetizer #(
        .MAX_BYTES  (MAX_BYTES),
        .ADDR_W     (9),
        .TIMEOUT_CYC(TO_CYC)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_last    (in_last),
        .in_ready   (in_ready),
        .tx_start_en(tx_start_en),
        .tx_byte_num(tx_byte_num),
        .tx_req     (tx_req),
        .tx_data    (tx_data),
        .tx_done    (tx_done),
        .busy       (busy),
        .dbg_state  (dbg_state)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model: packets as byte lists ----------------
    function automatic void model_close();
        int n;
        n = cur_q.size();
        if (n == 0) return;
        num_q.push_back(n);
        for (int i = 0; i < n; i += 4) begin
            logic [31:0] w;
            w = 32'h0;
            for (int k = 0; k < 4; k++) begin
                if (i + k < n) w[31-8*k -: 8] = cur_q[i+k];
            end
            exp_q.push_back(w);
        end
        cur_q.delete();
    endfunction

    function automatic bit model_accept(input logic [7:0] b, input logic last);
        cur_q.push_back(b);
        if (last || cur_q.size() == MAX_BYTES) begin
            model_close();
            return 1'b1;
        end
        return 1'b0;
    endfunction

    // ---------------- monitor ----------------
    always @(posedge clk) req_seen <= rst_n && tx_req && !tx_done;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_val = 32'h0;
        end else if (req_seen) begin
            if (exp_q.size() == 0) begin
                check("tx_data_unexpected_read", 32'd1, 32'd0);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("tx_data", tx_data, e);
                hold_val = e;
            end
        end else begin
            check("tx_data_hold", tx_data, hold_val);
        end
    end

    // ---------------- byte source driver ----------------
    task automatic drive_stream(input int gap_max);
        int g;
        int w;
        bit closed;
        @(negedge clk);
        while (src_data.size() > 0) begin
            g = $urandom_range(0, gap_max);
            in_valid = 1'b0;
            repeat (g) begin
                in_last = 1'($urandom_range(0, 1));
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = src_data[0];
            in_last  = src_last[0];
            w = 0;
            while (!in_ready && w < STALL_LIMIT) begin
                @(negedge clk);
                w++;
            end
            if (!in_ready) begin
                check("in_ready_stall_bound", 32'd0, 32'd1);
                in_valid = 1'b0;
                in_last  = 1'b0;
                src_data.delete();
                src_last.delete();
                return;
            end
            closed = model_accept(src_data.pop_front(), src_last.pop_front());
            @(negedge clk);
            if (closed) check("in_ready_after_close", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic push_bytes(input int n, input logic [7:0] first, input bit incr, input bit last_at_end);
        logic [7:0] b;
        b = first;
        for (int i = 0; i < n; i++) begin
            src_data.push_back(incr ? b : 8'($urandom_range(0, 255)));
            src_last.push_back(last_at_end && (i == n - 1));
            b = b + 8'd1;
        end
    endtask

    // ---------------- transmitter emulator ----------------
    task automatic serve_packet(input int abort_after, output int start_wait);
        int exp_num;
        int nwords;
        int extra;
        int len;
        int gap;
        start_wait = 0;
        @(negedge clk);
        while (!tx_start_en && start_wait < START_LIMIT) begin
            @(negedge clk);
            start_wait++;
        end
        if (!tx_start_en) begin
            check("start_seen", 32'd0, 32'd1);
            return;
        end
        if (num_q.size() == 0) begin
            check("start_expected", 32'd1, 32'd0);
            exp_num = 0;
        end else begin
            exp_num = num_q.pop_front();
        end
        check("tx_byte_num", 32'(tx_byte_num), 32'(exp_num));
        check("busy_in_start", 32'(busy), 32'd1);
        check("in_ready_in_start", 32'(in_ready), 32'd0);
        len = 0;
        while (tx_start_en && len < 8) begin
            len++;
            @(negedge clk);
        end
        check("start_len", 32'(len), 32'd2);
        nwords = (exp_num + 3) / 4;
        extra  = $urandom_range(1, 3);
        for (int i = 0; i < nwords + extra; i++) begin
            if (i == abort_after) return;
            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            if (i >= nwords) exp_q.push_back(32'h0);
            tx_req = 1'b1;
            @(negedge clk);
            tx_req = 1'b0;
        end
        gap = $urandom_range(0, 3);
        repeat (gap) @(negedge clk);
        tx_done = 1'b1;
        tx_req  = ($urandom_range(0, 3) == 0);
        @(negedge clk);
        tx_done = 1'b0;
        tx_req  = 1'b0;
        check("busy_after_done", 32'(busy), 32'd0);
        check("in_ready_after_done", 32'(in_ready), 32'd1);
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_tx_start_en", 32'(tx_start_en), 32'd0);
        check("rst_tx_byte_num", 32'(tx_byte_num), 32'd0);
        check("rst_tx_data", tx_data, 32'h0);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int sw;
        int sw2;
        int npk;
        bit seen;

        repeat (3) @(negedge clk);
        check_reset_values();
        rst_n = 1'b1;

        // 0x01..0x08 with last
        push_bytes(8, 8'h01, 1'b1, 1'b1);
        fork
            drive_stream(0);
            serve_packet(-1, sw);
        join

        // 0xA1..0xA5 with last
        push_bytes(5, 8'hA1, 1'b1, 1'b1);
        fork
            drive_stream(0);
            serve_packet(-1, sw);
        join

        // 1500 continuous bytes: closes at MAX_BYTES, remainder becomes the next packet
        push_bytes(1500, 8'h00, 1'b1, 1'b1);
        fork
            drive_stream(0);
            begin
                serve_packet(-1, sw);
                serve_packet(-1, sw2);
            end
        join

        // random packets with random gaps and random request spacing
        npk = 8;
        for (int p = 0; p < npk; p++) begin
            push_bytes($urandom_range(1, 40), 8'h00, 1'b0, 1'b1);
        end
        fork
            drive_stream(3);
            repeat (npk) serve_packet(-1, sw);
        join

        // reset in the middle of SEND
        push_bytes(8, 8'h30, 1'b1, 1'b1);
        fork
            drive_stream(0);
            serve_packet(2, sw);
        join
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_reset_values();
        exp_q.delete();
        num_q.delete();
        cur_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        push_bytes(4, 8'hC1, 1'b1, 1'b1);
        fork
            drive_stream(0);
            serve_packet(-1, sw);
        join

        // partial packet left idle
        src_data.push_back(8'h11); src_last.push_back(1'b0);
        src_data.push_back(8'h22); src_last.push_back(1'b0);
        src_data.push_back(8'h33); src_last.push_back(1'b0);
        drive_stream(0);
`ifdef PKTZ_TIMEOUT_FLUSH_EN
        model_close();
        serve_packet(-1, sw);
        check("timeout_close_delay", 32'((sw >= TO_CYC - 2) && (sw <= TO_CYC + 2)), 32'd1);
`else
        seen = 1'b0;
        repeat (10000) begin
            @(negedge clk);
            if (tx_start_en) seen = 1'b1;
        end
        check("no_start_when_idle", 32'(seen), 32'd0);
        check("in_ready_while_partial", 32'(in_ready), 32'd1);
        src_data.push_back(8'h44); src_last.push_back(1'b1);
        fork
            drive_stream(0);
            serve_packet(-1, sw);
        join
`endif

        repeat (4) @(negedge clk);
        check("scoreboard_drained", 32'(exp_q.size() + num_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #3000000;
        n_bad++;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $fatal(1, "watchdog");
    end

endmodule
